// File: rtl/sd_dac_ramp_if.sv
// Target-code handshake between a code source (master) and the sigma-delta DAC (slave).
interface sd_dac_ramp_if #(
   parameter int unsigned DAC_WIDTH = 9
);
   logic [DAC_WIDTH-1:0] din;
   logic                 din_valid;
   logic                 din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/sd_dac_ramp.sv
// First-order sigma-delta DAC with a slew-limited level that tracks a handshaked target
// and drains to zero on disable so the filtered reference never steps.
module sd_dac_ramp #(
   parameter int unsigned DAC_WIDTH  = 9,
   parameter int unsigned RAMP_STEP  = 1,
   parameter int unsigned UPDATE_DIV = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   sd_dac_ramp_if.slave         dbus,
   output logic                 analog_out,
   output logic [DAC_WIDTH-1:0] level,
   output logic                 at_target,
   output logic                 busy
);
   localparam int unsigned AW = DAC_WIDTH + 1;
   localparam int unsigned PW = $clog2(UPDATE_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(UPDATE_DIV - 1);
   localparam logic [AW-1:0] STEP       = AW'(RAMP_STEP);

   typedef enum logic [2:0] {
      ST_OFF,
      ST_LOAD,
      ST_RAMP,
      ST_HOLD,
      ST_DRAIN
   } state_e;

   state_e               state_q, state_d;
   logic [DAC_WIDTH-1:0] target_q, target_d;
   logic [DAC_WIDTH-1:0] level_q, level_d;
   // Only the low DAC_WIDTH bits of the accumulator carry over; the top bit is the output carry.
   logic [DAC_WIDTH-1:0] acc_q, acc_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic                 out_q, out_d;
   logic                 at_q, at_d;
   logic                 busy_q, busy_d;

   logic                 din_ready_c;
   logic                 xfer;
   logic                 slewing;
   logic                 tick;
   logic                 rising;
   logic [AW-1:0]        lvl_w, tgt_w, diff, stp, acc_sum;
   logic [DAC_WIDTH-1:0] stepped;

   assign din_ready_c    = enable && ((state_q == ST_HOLD) || (state_q == ST_RAMP));
   assign dbus.din_ready = din_ready_c;
   assign xfer           = dbus.din_valid && din_ready_c;
   assign slewing        = (state_q == ST_RAMP) || (state_q == ST_DRAIN);
   assign tick           = slewing && (presc_q == PRESC_LAST);

   // Slew step: move toward target by at most STEP, never past it.
   assign lvl_w   = AW'(level_q);
   assign tgt_w   = AW'(target_q);
   assign rising  = tgt_w >= lvl_w;
   assign diff    = rising ? (tgt_w - lvl_w) : (lvl_w - tgt_w);
   assign stp     = (diff < STEP) ? diff : STEP;
   assign stepped = rising ? DAC_WIDTH'(lvl_w + stp) : DAC_WIDTH'(lvl_w - stp);

   assign acc_sum = AW'(acc_q) + AW'(level_q);

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      level_d  = level_q;
      presc_d  = '0;
      acc_d    = acc_sum[DAC_WIDTH-1:0];
      out_d    = acc_sum[DAC_WIDTH];

      if (tick) begin
         level_d = stepped;
      end

      case (state_q)
         ST_OFF: begin
            acc_d = '0;
            out_d = 1'b0;
            if (enable) begin
               state_d  = ST_HOLD;
               target_d = '0;
               level_d  = '0;
            end
         end
         ST_HOLD: begin
            if (!enable) begin
               state_d = ST_DRAIN;
            end else if (xfer) begin
               state_d  = ST_LOAD;
               target_d = dbus.din;
            end
         end
         ST_RAMP: begin
            if (!enable) begin
               state_d = ST_DRAIN;
            end else if (xfer) begin
               state_d  = ST_LOAD;
               target_d = dbus.din;
            end else if (level_q == target_q) begin
               state_d = ST_HOLD;
            end
         end
         ST_LOAD: begin
            state_d = (level_q == target_q) ? ST_HOLD : ST_RAMP;
         end
         ST_DRAIN: begin
            if (level_q == '0) begin
               state_d = ST_OFF;
            end
         end
         default: begin
            state_d = ST_OFF;
         end
      endcase

      if (state_d == ST_DRAIN) begin
         target_d = '0;
      end

      // Prescaler restarts on every state change so the first step lands UPDATE_DIV edges after entry.
      if (slewing && (state_d == state_q)) begin
         presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      end

      at_d   = (state_d == ST_HOLD);
      busy_d = (state_d == ST_LOAD) || (state_d == ST_RAMP) || (state_d == ST_DRAIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_OFF;
         target_q <= '0;
         level_q  <= '0;
         acc_q    <= '0;
         presc_q  <= '0;
         out_q    <= 1'b0;
         at_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         level_q  <= level_d;
         acc_q    <= acc_d;
         presc_q  <= presc_d;
         out_q    <= out_d;
         at_q     <= at_d;
         busy_q   <= busy_d;
      end
   end

   assign analog_out = out_q;
   assign level      = level_q;
   assign at_target  = at_q;
   assign busy       = busy_q;
endmodule

// File: tb/tb_sd_dac_ramp.sv
// Bench for sd_dac_ramp: directed vector table, corner-case sequences and a random run,
// all compared every cycle against a behavioural model of the ramping DAC.
module tb_sd_dac_ramp;
   localparam int W    = 9;
   localparam int STEP = 8;
   localparam int DIV  = 4;
   localparam int FULL = 1 << W;

   localparam int M_OFF   = 0;
   localparam int M_LOAD  = 1;
   localparam int M_RAMP  = 2;
   localparam int M_HOLD  = 3;
   localparam int M_DRAIN = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         enable;
   logic         analog_out;
   logic [W-1:0] level;
   logic         at_target;
   logic         busy;

   sd_dac_ramp_if #(.DAC_WIDTH(W)) dbus ();

   sd_dac_ramp #(
      .DAC_WIDTH (W),
      .RAMP_STEP (STEP),
      .UPDATE_DIV(DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .dbus      (dbus),
      .analog_out(analog_out),
      .level     (level),
      .at_target (at_target),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int    checks   = 0;
   int    failures = 0;
   string tag      = "init";

   int m_st, m_level, m_target, m_since, m_acc;
   bit m_out, m_en;

   typedef struct {
      bit en;
      int din;
      bit vld;
      int lvl;
      bit busy;
      bit at;
      bit rdy;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = M_OFF; m_level = 0; m_target = 0; m_since = 0; m_acc = 0; m_out = 1'b0; m_en = 1'b0;
   endtask

   // One clock edge of the reference: slew tick from edges-since-entry, modulator from mod arithmetic.
   task automatic model_edge(input bit en, input int d, input bit v);
      int nst, ntgt, nlvl, gap, mv;
      bit slew, xfer;
      nst  = m_st; ntgt = m_target; nlvl = m_level;
      slew = (m_st == M_RAMP) || (m_st == M_DRAIN);
      xfer = en && v && (m_st == M_HOLD || m_st == M_RAMP);
      if (slew && ((m_since + 1) % DIV) == 0) begin
         gap  = m_target - m_level;
         mv   = (gap < 0) ? -gap : gap;
         if (mv > STEP) mv = STEP;
         nlvl = (gap < 0) ? m_level - mv : m_level + mv;
      end
      if (m_st == M_OFF) begin
         m_acc = 0;
         m_out = 1'b0;
      end else begin
         m_acc = (m_acc % FULL) + m_level;
         m_out = (m_acc >= FULL);
      end
      case (m_st)
         M_OFF:   if (en) begin nst = M_HOLD; ntgt = 0; nlvl = 0; end
         M_LOAD:  nst = (m_level == m_target) ? M_HOLD : M_RAMP;
         M_DRAIN: if (m_level == 0) nst = M_OFF;
         default: begin
            if (!en) nst = M_DRAIN;
            else if (xfer) begin nst = M_LOAD; ntgt = d; end
            else if (m_st == M_RAMP && m_level == m_target) nst = M_HOLD;
         end
      endcase
      if (nst == M_DRAIN) ntgt = 0;
      m_since  = (slew && nst == m_st) ? m_since + 1 : 0;
      m_st     = nst;
      m_target = ntgt;
      m_level  = nlvl;
      m_en     = en;
   endtask

   task automatic compare_all();
      check({tag, ".level"},      int'(level),          m_level);
      check({tag, ".busy"},       int'(busy),           int'(m_st == M_LOAD || m_st == M_RAMP || m_st == M_DRAIN));
      check({tag, ".at_target"},  int'(at_target),      int'(m_st == M_HOLD));
      check({tag, ".din_ready"},  int'(dbus.din_ready), int'(m_en && (m_st == M_HOLD || m_st == M_RAMP)));
      check({tag, ".analog_out"}, int'(analog_out),     int'(m_out));
   endtask

   task automatic step(input bit en, input int d, input bit v);
      enable         = en;
      dbus.din       = W'(d);
      dbus.din_valid = v;
      model_edge(en, d, v);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic settle_to(input int code);
      step(1'b1, code, 1'b1);
      for (int i = 0; i < 2000 && !(at_target && int'(level) == code); i++) step(1'b1, 0, 1'b0);
      check({tag, ".settled"}, int'(at_target && int'(level) == code), 1);
   endtask

   initial begin
      vec_t tbl[12];
      int   codes[3];
      int   q[$];
      int   last, ones, acc_cnt, last_acc;
      bit   pre_rdy, prev_rdy, seen_off, en_r;

      rst_n = 1'b0; enable = 1'b0; dbus.din = '0; dbus.din_valid = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      tag = "reset";
      compare_all();
      rst_n = 1'b1;

      // Enable, load 16, ramp in two steps of 8, settle in HOLD.
      tbl[0]  = '{1'b1,  0, 1'b0,  0, 1'b0, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 16, 1'b1,  0, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1,  0, 1'b0,  0, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1,  0, 1'b0,  0, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1,  0, 1'b0,  0, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{1'b1,  0, 1'b0,  0, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b1,  0, 1'b0,  8, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b1,  0, 1'b0,  8, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b1,  0, 1'b0,  8, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{1'b1,  0, 1'b0,  8, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b1,  0, 1'b0, 16, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b1,  0, 1'b0, 16, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 12; i++) begin
         tag = $sformatf("t1[%0d]", i);
         step(tbl[i].en, tbl[i].din, tbl[i].vld);
         check({tag, ".vec_level"}, int'(level),          tbl[i].lvl);
         check({tag, ".vec_busy"},  int'(busy),           int'(tbl[i].busy));
         check({tag, ".vec_at"},    int'(at_target),      int'(tbl[i].at));
         check({tag, ".vec_ready"}, int'(dbus.din_ready), int'(tbl[i].rdy));
      end

      // Pulse density over 512-clock windows at constant level.
      codes = '{128, 0, 511};
      for (int c = 0; c < 3; c++) begin
         tag = $sformatf("t2_%0d", codes[c]);
         settle_to(codes[c]);
         for (int w = 0; w < 4; w++) begin
            ones = 0;
            for (int k = 0; k < FULL; k++) begin
               step(1'b1, 0, 1'b0);
               ones += int'(analog_out);
            end
            check($sformatf("%s.ones_win%0d", tag, w), ones, codes[c]);
         end
      end

      // Retarget downward mid-ramp: no undershoot below the new target.
      tag = "t3";
      settle_to(0);
      step(1'b1, 200, 1'b1);
      for (int i = 0; i < 400 && int'(level) != 40; i++) step(1'b1, 0, 1'b0);
      check("t3.reach40", int'(level), 40);
      step(1'b1, 20, 1'b1);
      check("t3.ready_low", int'(dbus.din_ready), 0);
      q.delete(); last = int'(level);
      for (int i = 0; i < 200 && !at_target; i++) begin
         step(1'b1, 0, 1'b0);
         if (int'(level) != last) begin last = int'(level); q.push_back(last); end
      end
      check("t3.nsteps", q.size(), 3);
      check("t3.step0", (q.size() > 0) ? q[0] : -1, 32);
      check("t3.step1", (q.size() > 1) ? q[1] : -1, 24);
      check("t3.step2", (q.size() > 2) ? q[2] : -1, 20);
      check("t3.final", int'(level), 20);

      // Drain on disable, then drain with enable re-raised.
      tag = "t4";
      settle_to(24);
      step(1'b0, 0, 1'b0);
      check("t4.ready", int'(dbus.din_ready), 0);
      check("t4.busy", int'(busy), 1);
      q.delete(); last = 24;
      for (int i = 0; i < 200 && busy; i++) begin
         step(1'b0, 0, 1'b0);
         if (int'(level) != last) begin last = int'(level); q.push_back(last); end
      end
      check("t4.nsteps", q.size(), 3);
      check("t4.step0", (q.size() > 0) ? q[0] : -1, 16);
      check("t4.step1", (q.size() > 1) ? q[1] : -1, 8);
      check("t4.step2", (q.size() > 2) ? q[2] : -1, 0);
      check("t4.off_busy", int'(busy), 0);
      check("t4.off_at", int'(at_target), 0);
      check("t4.off_out", int'(analog_out), 0);
      step(1'b1, 0, 1'b0);
      settle_to(24);
      step(1'b0, 0, 1'b0);
      seen_off = 1'b0;
      for (int i = 0; i < 200 && !seen_off; i++) begin
         step(1'b1, 0, 1'b0);
         if (!busy && !at_target) seen_off = 1'b1;
      end
      check("t4.reen_off", int'(seen_off), 1);
      step(1'b1, 0, 1'b0);
      check("t4.reen_hold", int'(at_target), 1);

      // Continuous valid: one transfer per non-LOAD cycle, last one wins.
      tag = "t6";
      acc_cnt = 0; last_acc = -1; prev_rdy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         int d;
         d       = int'($urandom_range(0, FULL - 1));
         pre_rdy = dbus.din_ready;
         if (i > 0) check("t6.alternate", int'(pre_rdy), int'(!prev_rdy));
         if (pre_rdy) begin acc_cnt++; last_acc = d; end
         prev_rdy = pre_rdy;
         step(1'b1, d, 1'b1);
      end
      check("t6.transfers", acc_cnt, 20);
      for (int i = 0; i < 600 && !at_target; i++) step(1'b1, 0, 1'b0);
      check("t6.last_target", int'(level), last_acc);

      // Asynchronous reset mid-ramp.
      tag = "t5";
      step(1'b1, 300, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 0, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      check("t5.rst_level", int'(level), 0);
      check("t5.rst_busy", int'(busy), 0);
      check("t5.rst_at", int'(at_target), 0);
      check("t5.rst_ready", int'(dbus.din_ready), 0);
      check("t5.rst_out", int'(analog_out), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b0, 0, 1'b0);
      check("t5.off_level", int'(level), 0);
      step(1'b1, 0, 1'b0);
      check("t5.hold", int'(at_target), 1);

      // Random traffic against the model.
      tag = "rand";
      en_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 2) en_r = !en_r;
         step(en_r, int'($urandom_range(0, FULL - 1)), ($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
